mux_arbiter_4x1: RTL and testbench

Round-robin arbiter and sequencer for the shared 4-to-1 single-bit selection datapath. Four requesters compete for the shared output line. The block grants one requester at a time and drives the one-hot grant vector and the 2-bit select. It also registers the selected data bit. Grant hold time is bounded by `MAX_HOLD` so no requester can starve the others.

---
 rtl/mux_arbiter_4x1.sv | 113 +++++++++++
 tb/tb_mux_arbiter_4x1.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_4x1.sv
// Round-robin arbiter for a shared 4-to-1 single-bit datapath.
// Grant hold time is capped at MAX_HOLD cycles; the selected data bit is registered.
//
// state | meaning
// IDLE  | no grant active, grant = 0, sel holds last granted index
// GRANT | one requester owns the line, hold_cnt counts its cycles
module mux_arbiter_4x1 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       data_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic       data_out_q, data_out_d;

  logic [1:0] winner;
  logic       found;
  logic       grant_end;

  // Search starts just after the last winner, so the current holder is considered last.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[last_q + 2'(k)]) begin
        winner = last_q + 2'(k);
        found  = 1'b1;
      end
    end
  end

  assign grant_end = !req[sel_q] || (hold_cnt_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        if (found) begin
          state_d    = GRANT;
          grant_d    = 4'b0001 << winner;
          sel_d      = winner;
          last_d     = winner;
          hold_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          if (found) begin
            grant_d    = 4'b0001 << winner;
            sel_d      = winner;
            last_d     = winner;
            hold_cnt_d = 8'd0;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
    data_out_d = (state_d == GRANT) ? data_in[sel_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= 2'd3;
      hold_cnt_q <= 8'd0;
      grant_q    <= 4'b0000;
      sel_q      <= 2'd0;
      data_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      data_out_q <= data_out_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign busy     = |grant_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_mux_arbiter_4x1.sv
// Bench for mux_arbiter_4x1: two instances (MAX_HOLD 8 and 1) share stimulus and
// are compared against a cycle-counting ownership model of the arbitration rules.
module tb_mux_arbiter_4x1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] data_in = 4'b0000;

  logic [3:0] g8, g1;
  logic [1:0] s8, s1;
  logic       b8, b1, d8, d1;

  int n_checks = 0;
  int n_fail = 0;

  // Model state per instance: 0 -> MAX_HOLD=8, 1 -> MAX_HOLD=1
  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  int m_sel   [2];
  bit m_dout  [2];
  int maxh    [2] = '{8, 1};

  mux_arbiter_4x1 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .req(req), .data_in(data_in),
    .grant(g8), .sel(s8), .busy(b8), .data_out(d8)
  );

  mux_arbiter_4x1 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .data_in(data_in),
    .grant(g1), .sel(s1), .busy(b1), .data_out(d1)
  );

  always #5 clk = ~clk;

  function automatic void model_step(int m);
    int  w;
    bit  rearb;
    if (!reset_n) begin
      m_owner[m] = -1;
      m_last[m]  = 3;
      m_held[m]  = 0;
      m_sel[m]   = 0;
      m_dout[m]  = 1'b0;
      return;
    end
    rearb = (m_owner[m] < 0) || !req[m_owner[m]] || (m_held[m] >= maxh[m]);
    if (rearb) begin
      w = -1;
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (m_last[m] + i) % 4;
        if (w < 0 && req[c]) w = c;
      end
      if (w < 0) begin
        m_owner[m] = -1;
      end else begin
        m_owner[m] = w;
        m_last[m]  = w;
        m_sel[m]   = w;
        m_held[m]  = 1;
      end
    end else begin
      m_held[m] = m_held[m] + 1;
    end
    m_dout[m] = (m_owner[m] >= 0) ? data_in[m_owner[m]] : 1'b0;
  endfunction

  function automatic logic [3:0] model_grant(int m);
    return (m_owner[m] >= 0) ? (4'b0001 << m_owner[m]) : 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 4'b1111;
    data_in = 4'b1111;
    repeat (3) tick();
    n_checks++;
    if (g8 !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", g8); end
    n_checks++;
    if (s8 !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", s8); end
    n_checks++;
    if (b8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b8); end
    n_checks++;
    if (d8 !== 1'b0) begin n_fail++; $display("FAIL reset_data_out: got %b want 0", d8); end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (g8 !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", g8); end
    n_checks++;
    if (g1 !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant_mh1: got %b want 0001", g1); end
  endtask

  task automatic test_single_hold();
    req = 4'b0000;
    repeat (2) tick();
    req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (g8 !== 4'b0100 || s8 !== 2'd2 || b8 !== 1'b1) begin
        n_fail++;
        $display("FAIL single_hold cyc %0d: got grant=%b sel=%0d busy=%b want 0100/2/1", k, g8, s8, b8);
      end
      n_checks++;
      if (g1 !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_hold_mh1 cyc %0d: got %b want 0100", k, g1);
      end
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (g8 !== 4'b0000 || b8 !== 1'b0 || s8 !== 2'd2) begin
      n_fail++;
      $display("FAIL single_release: got grant=%b busy=%b sel=%0d want 0000/0/2", g8, b8, s8);
    end
  endtask

  task automatic test_full_contention();
    reset_n = 1'b0;
    req = 4'b1111;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [3:0] exp8, exp1;
      tick();
      exp8 = 4'b0001 << ((k / 8) % 4);
      exp1 = 4'b0001 << (k % 4);
      n_checks++;
      if (g8 !== exp8) begin
        n_fail++;
        $display("FAIL contention cyc %0d: got %b want %b", k, g8, exp8);
      end
      n_checks++;
      if (g1 !== exp1) begin
        n_fail++;
        $display("FAIL rotate_mh1 cyc %0d: got %b want %b", k, g1, exp1);
      end
    end
  endtask

  task automatic test_early_release();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (g8 !== 4'b0001) begin
        n_fail++;
        $display("FAIL early_hold0 cyc %0d: got %b want 0001", k, g8);
      end
    end
    req = 4'b0010;
    tick();
    n_checks++;
    if (g8 !== 4'b0010) begin n_fail++; $display("FAIL early_move: got %b want 0010", g8); end
    req = 4'b0011;
    for (int k = 0; k < 7; k++) begin
      tick();
      n_checks++;
      if (g8 !== 4'b0010) begin
        n_fail++;
        $display("FAIL early_hold1 cyc %0d: got %b want 0010", k, g8);
      end
      n_checks++;
      if (g1 !== model_grant(1)) begin
        n_fail++;
        $display("FAIL early_mh1 cyc %0d: got %b want %b", k, g1, model_grant(1));
      end
    end
    tick();
    n_checks++;
    if (g8 !== 4'b0001) begin n_fail++; $display("FAIL early_bound: got %b want 0001", g8); end
  endtask

  task automatic test_data_path();
    bit b;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 4'b1000;
    data_in = 4'b0111;
    tick();
    n_checks++;
    if (g8 !== 4'b1000 || d8 !== 1'b0) begin
      n_fail++;
      $display("FAIL data_first: got grant=%b dout=%b want 1000/0", g8, d8);
    end
    b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b = ~b;
      data_in = {b, 3'b111};
      tick();
      n_checks++;
      if (d8 !== b) begin
        n_fail++;
        $display("FAIL data_follow cyc %0d: got %b want %b", k, d8, b);
      end
    end
    req = 4'b0000;
    data_in = 4'b1111;
    repeat (2) begin
      tick();
      n_checks++;
      if (d8 !== 1'b0 || g8 !== 4'b0000) begin
        n_fail++;
        $display("FAIL data_idle: got dout=%b grant=%b want 0/0000", d8, g8);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 4'b0100;
    data_in = 4'b0100;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (g8 !== 4'b0000 || s8 !== 2'd0 || b8 !== 1'b0 || d8 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got grant=%b sel=%0d busy=%b dout=%b want all 0", g8, s8, b8, d8);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (g8 !== 4'b0100 || d8 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_restart: got grant=%b dout=%b want 0100/1", g8, d8);
    end
    req = 4'b0101;
    for (int k = 1; k < 8; k++) begin
      tick();
      n_checks++;
      if (g8 !== 4'b0100) begin
        n_fail++;
        $display("FAIL midreset_hold cyc %0d: got %b want 0100", k, g8);
      end
    end
    tick();
    n_checks++;
    if (g8 !== 4'b0001) begin n_fail++; $display("FAIL midreset_bound: got %b want 0001", g8); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      data_in = 4'($urandom_range(0, 15));
      tick();
      for (int m = 0; m < 2; m++) begin
        logic [3:0] ag;
        logic [1:0] as;
        logic       ab, ad;
        ag = (m == 0) ? g8 : g1;
        as = (m == 0) ? s8 : s1;
        ab = (m == 0) ? b8 : b1;
        ad = (m == 0) ? d8 : d1;
        n_checks++;
        if (ag !== model_grant(m) || as !== 2'(m_sel[m]) || ab !== (m_owner[m] >= 0) || ad !== m_dout[m]) begin
          n_fail++;
          $display("FAIL random mh=%0d cyc %0d: got g=%b s=%0d b=%b d=%b want g=%b s=%0d b=%b d=%b",
                   maxh[m], k, ag, as, ab, ad, model_grant(m), m_sel[m], (m_owner[m] >= 0), m_dout[m]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_full_contention();
    test_early_release();
    test_data_path();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
